// File: rtl/exclusive_min_n_if.sv
// Race-input / result bundle for the exclusive-min detector.
// The master drives set/a; the slave (detector) returns the window results.
interface exclusive_min_n_if #(
    parameter int N  = 4,
    parameter int TW = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          set;
    logic [N-1:0]  a;
    logic          q;
    logic          win_valid;
    logic [IW-1:0] win_idx;
    logic [TW-1:0] win_time;
    logic          tie;
    logic          timeout;
    logic          busy;

    modport master (
        output set, a,
        input  q, win_valid, win_idx, win_time, tie, timeout, busy
    );

    modport slave (
        input  set, a,
        output q, win_valid, win_idx, win_time, tie, timeout, busy
    );
endinterface

// File: rtl/exclusive_min_n.sv
// N-input clocked exclusive-min detector: reports the unique earliest event after set,
// inhibits on a first-place tie, and saturates to "infinity" when the window expires.
//
// state | meaning
// IDLE  | after reset, nothing armed, inputs ignored
// ARMED | window open, counting cycles and watching for the first event
// DONE  | result (winner, tie or timeout) held until next set
module exclusive_min_n #(
    parameter int N    = 4,
    parameter int TW   = 8,
    parameter int MODE = 1
) (
    input  logic                 aclk_i,
    input  logic                 grst_i,
    exclusive_min_n_if.slave     bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [TW-1:0] T_INF    = {TW{1'b1}};
    localparam logic [TW-1:0] CNT_LAST = {{(TW-1){1'b1}}, 1'b0};
    localparam logic [N-1:0]  PREV_RST = (MODE == 2) ? {N{1'b1}} : {N{1'b0}};
    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]    state_q,     state_d;
    logic [TW-1:0] cnt_q,       cnt_d;
    logic [N-1:0]  prev_q,      prev_d;
    logic          q_q,         q_d;
    logic          win_valid_q, win_valid_d;
    logic [IW-1:0] win_idx_q,   win_idx_d;
    logic [TW-1:0] win_time_q,  win_time_d;
    logic          tie_q,       tie_d;
    logic          timeout_q,   timeout_d;

    logic [N-1:0]  ev;
    logic          ev_any;
    logic          ev_one;
    logic [IW-1:0] ev_idx;

    always_comb begin
        ev = bus.a;
        case (MODE)
            1:       ev = bus.a & ~prev_q;
            2:       ev = ~bus.a & prev_q;
            default: ev = bus.a;
        endcase
    end

    // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
    always_comb begin
        ev_any = |ev;
        ev_one = ev_any && ((ev & (ev - ONE_N)) == '0);
        ev_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ev[i]) ev_idx = i[IW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_d      = bus.a;
        q_d         = 1'b0;
        win_valid_d = win_valid_q;
        win_idx_d   = win_idx_q;
        win_time_d  = win_time_q;
        tie_d       = tie_q;
        timeout_d   = timeout_q;

        if (bus.set) begin
            state_d     = ARMED;
            cnt_d       = '0;
            win_valid_d = 1'b0;
            win_idx_d   = '0;
            win_time_d  = T_INF;
            tie_d       = 1'b0;
            timeout_d   = 1'b0;
        end else if (state_q == ARMED) begin
            if (ev_one) begin
                state_d     = DONE;
                win_valid_d = 1'b1;
                win_idx_d   = ev_idx;
                win_time_d  = cnt_q;
                q_d         = 1'b1;
            end else if (ev_any) begin
                state_d = DONE;
                tie_d   = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                state_d   = DONE;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk_i or posedge grst_i) begin
        if (grst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prev_q      <= PREV_RST;
            q_q         <= 1'b0;
            win_valid_q <= 1'b0;
            win_idx_q   <= '0;
            win_time_q  <= T_INF;
            tie_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            q_q         <= q_d;
            win_valid_q <= win_valid_d;
            win_idx_q   <= win_idx_d;
            win_time_q  <= win_time_d;
            tie_q       <= tie_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_idx   = win_idx_q;
    assign bus.win_time  = win_time_q;
    assign bus.tie       = tie_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = (state_q == ARMED);
endmodule
